// File: rtl/updn_seq_pkg.sv
// Shared types and idle control levels for the up/down counter sequencer.
package updn_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Counter control levels that leave the counter untouched.
    localparam logic IDLE_LD_CNT    = 1'b1;
    localparam logic IDLE_UPDN_CNT  = 1'b0;
    localparam logic IDLE_COUNT_ENB = 1'b0;

endpackage

// File: rtl/updn_cnt_model.sv
// Expected-value model of the up/down counter plus the data_out compare and
// saturating error counter.
module updn_cnt_model #(
    parameter int WIDTH = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld_cnt,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_updn_cnt,
    input  logic             i_count_enb,
    input  logic [WIDTH-1:0] i_data_out,
    input  logic             i_chk_en,
    output logic [WIDTH-1:0] o_exp_value,
    output logic             o_exp_valid,
    output logic             o_mismatch,
    output logic [ERR_W-1:0] o_err_count
);

    logic [WIDTH-1:0] r_exp_value;
    logic             r_exp_valid;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_err_count;
    logic             w_miscompare;

    assign w_miscompare = i_chk_en && r_exp_valid && (i_data_out != r_exp_value);

    // Track the counter: load wins, counting is ignored until the first load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_value <= {WIDTH{1'b0}};
            r_exp_valid <= 1'b0;
        end else if (!i_ld_cnt) begin
            r_exp_value <= i_data_in;
            r_exp_valid <= 1'b1;
        end else if (i_count_enb && r_exp_valid) begin
            r_exp_value <= i_updn_cnt ? (r_exp_value + WIDTH'(1)) : (r_exp_value - WIDTH'(1));
        end else begin
            r_exp_value <= r_exp_value;
        end
    end

    // Sticky mismatch flag and saturating error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch  <= 1'b0;
            r_err_count <= {ERR_W{1'b0}};
        end else if (w_miscompare) begin
            r_mismatch <= 1'b1;
            if (r_err_count != {ERR_W{1'b1}}) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end else begin
                r_err_count <= r_err_count;
            end
        end else begin
            r_mismatch  <= r_mismatch;
            r_err_count <= r_err_count;
        end
    end

    assign o_exp_value = r_exp_value;
    assign o_exp_valid = r_exp_valid;
    assign o_mismatch  = r_mismatch;
    assign o_err_count = r_err_count;

endmodule

// File: rtl/updn_cnt_sequencer.sv
// Command-driven initiator for the 16-bit up/down counter: turns LOAD/UP/DOWN/HOLD
// commands into registered counter controls and checks the counter output.
module updn_cnt_sequencer
    import updn_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_done,
    output logic [WIDTH-1:0] cnt_data_in,
    output logic             cnt_ld_cnt,
    output logic             cnt_updn_cnt,
    output logic             cnt_count_enb,
    input  logic [WIDTH-1:0] cnt_data_out,
    input  logic             chk_en,
    output logic [WIDTH-1:0] exp_value,
    output logic             exp_valid,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [LEN_W-1:0] STEP_LAST = LEN_W'(1);

    state_e           r_state;
    logic [LEN_W-1:0] r_steps;
    logic             r_cmd_ready;
    logic             r_cmd_done;
    logic [WIDTH-1:0] r_data_in;
    logic             r_ld_cnt;
    logic             r_updn_cnt;
    logic             r_count_enb;

    state_e           w_state_nxt;
    logic [LEN_W-1:0] w_steps_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_data_in_nxt;
    logic             w_ld_cnt_nxt;
    logic             w_updn_cnt_nxt;
    logic             w_count_enb_nxt;
    logic             w_accept;
    op_e              w_op;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_op     = op_e'(cmd_op);

    // Next state and next control levels; controls fall back to idle unless an op holds them.
    always_comb begin
        w_state_nxt     = r_state;
        w_steps_nxt     = r_steps;
        w_done_nxt      = 1'b0;
        w_data_in_nxt   = {WIDTH{1'b0}};
        w_ld_cnt_nxt    = IDLE_LD_CNT;
        w_updn_cnt_nxt  = IDLE_UPDN_CNT;
        w_count_enb_nxt = IDLE_COUNT_ENB;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_LOAD) begin
                        w_state_nxt   = ST_LOAD;
                        w_ld_cnt_nxt  = 1'b0;
                        w_data_in_nxt = cmd_data;
                    end else if (cmd_len == {LEN_W{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt     = ST_RUN;
                        w_steps_nxt     = cmd_len;
                        w_count_enb_nxt = (w_op != OP_HOLD);
                        w_updn_cnt_nxt  = (w_op == OP_UP);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end
            ST_RUN: begin
                if (r_steps == STEP_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_steps_nxt     = r_steps - LEN_W'(1);
                    w_count_enb_nxt = r_count_enb;
                    w_updn_cnt_nxt  = r_updn_cnt;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, step counter and registered counter controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_steps     <= {LEN_W{1'b0}};
            r_cmd_ready <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_data_in   <= {WIDTH{1'b0}};
            r_ld_cnt    <= IDLE_LD_CNT;
            r_updn_cnt  <= IDLE_UPDN_CNT;
            r_count_enb <= IDLE_COUNT_ENB;
        end else begin
            r_state     <= w_state_nxt;
            r_steps     <= w_steps_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_cmd_done  <= w_done_nxt;
            r_data_in   <= w_data_in_nxt;
            r_ld_cnt    <= w_ld_cnt_nxt;
            r_updn_cnt  <= w_updn_cnt_nxt;
            r_count_enb <= w_count_enb_nxt;
        end
    end

    updn_cnt_model #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_model (
        .clk         (clk),
        .rst         (rst),
        .i_ld_cnt    (r_ld_cnt),
        .i_data_in   (r_data_in),
        .i_updn_cnt  (r_updn_cnt),
        .i_count_enb (r_count_enb),
        .i_data_out  (cnt_data_out),
        .i_chk_en    (chk_en),
        .o_exp_value (exp_value),
        .o_exp_valid (exp_valid),
        .o_mismatch  (mismatch),
        .o_err_count (err_count)
    );

    assign cmd_ready     = r_cmd_ready;
    assign cmd_done      = r_cmd_done;
    assign cnt_data_in   = r_data_in;
    assign cnt_ld_cnt    = r_ld_cnt;
    assign cnt_updn_cnt  = r_updn_cnt;
    assign cnt_count_enb = r_count_enb;

endmodule

// File: tb/tb_updn_cnt_sequencer.sv
// Bench for updn_cnt_sequencer: drives commands into the sequencer, closes the loop
// through a behavioural counter and scores each completed command from a queue.
module tb_updn_cnt_sequencer;
    import updn_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [7:0]  cmd_len;
    logic        cmd_done;
    logic [15:0] cnt_data_in;
    logic        cnt_ld_cnt;
    logic        cnt_updn_cnt;
    logic        cnt_count_enb;
    logic [15:0] cnt_data_out;
    logic        chk_en;
    logic [15:0] exp_value;
    logic        exp_valid;
    logic        mismatch;
    logic [7:0]  err_count;

    updn_cnt_sequencer #(.WIDTH(16), .LEN_W(8), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_done(cmd_done),
        .cnt_data_in(cnt_data_in), .cnt_ld_cnt(cnt_ld_cnt), .cnt_updn_cnt(cnt_updn_cnt),
        .cnt_count_enb(cnt_count_enb), .cnt_data_out(cnt_data_out), .chk_en(chk_en),
        .exp_value(exp_value), .exp_valid(exp_valid), .mismatch(mismatch),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural counter with an optional stuck-at-zero output.
    logic [15:0] cnt_q = 16'h0000;
    logic        fault = 1'b0;
    always @(posedge clk) begin
        if (!cnt_ld_cnt) cnt_q <= cnt_data_in;
        else if (cnt_count_enb) cnt_q <= cnt_updn_cnt ? cnt_q + 16'd1 : cnt_q - 16'd1;
    end
    assign cnt_data_out = fault ? 16'h0000 : cnt_q;

    int enb_total = 0;
    int ld_total = 0;
    int done_total = 0;
    always @(negedge clk) begin
        if (cnt_count_enb) enb_total <= enb_total + 1;
        if (!cnt_ld_cnt) ld_total <= ld_total + 1;
        if (cmd_done) done_total <= done_total + 1;
    end

    typedef struct {
        logic [15:0] val;
        int          lat;
        int          enb;
        int          ld;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_val = 16'h0000;
    int          snap_enb, snap_ld, snap_done;
    time         t_acc;
    int          errors = 0;
    int          checks = 0;

    localparam logic [59:0] RESET_VEC = {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0,
                                         16'h0000, 1'b0, 1'b0, 8'h00};
    logic [59:0] out_vec;
    assign out_vec = {cmd_ready, cmd_done, cnt_data_in, cnt_ld_cnt, cnt_updn_cnt, cnt_count_enb,
                      exp_value, exp_valid, mismatch, err_count};

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] data, input logic [7:0] len);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, t);
        end
        case (op)
            OP_LOAD: m_val = data;
            OP_UP:   m_val = m_val + 16'(len);
            OP_DOWN: m_val = m_val - 16'(len);
            default: m_val = m_val;
        endcase
        e.val = m_val;
        e.lat = (op == OP_LOAD) ? 2 : ((len == 8'd0) ? 1 : int'(len) + 1);
        e.enb = (op == OP_UP || op == OP_DOWN) ? int'(len) : 0;
        e.ld  = (op == OP_LOAD) ? 1 : 0;
        sb.push_back(e);
        snap_enb  = enb_total;
        snap_ld   = ld_total;
        snap_done = done_total;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        @(posedge clk);
        t_acc = $time;
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int   n;
        int   lat;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (cmd_done === 1'b1 || n >= 600) break;
        end
        lat = int'(($time - t_acc) / 10) + 1;
        checks++;
        if (cmd_done !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: cmd_done=%b queue=%0d, required done", name, cmd_done, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, e.lat);
        end
        checks++;
        if (exp_value !== e.val) begin
            errors++;
            $display("FAIL %s_exp_value: got %h, required %h", name, exp_value, e.val);
        end
        checks++;
        if (cnt_data_out !== e.val) begin
            errors++;
            $display("FAIL %s_data_out: got %h, required %h", name, cnt_data_out, e.val);
        end
        checks++;
        if (exp_valid !== 1'b1 || mismatch !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: exp_valid=%b mismatch=%b, required 1/0", name, exp_valid, mismatch);
        end
        checks++;
        if (enb_total - snap_enb != e.enb) begin
            errors++;
            $display("FAIL %s_enb_cycles: got %0d, required %0d", name, enb_total - snap_enb, e.enb);
        end
        checks++;
        if (ld_total - snap_ld != e.ld) begin
            errors++;
            $display("FAIL %s_ld_cycles: got %0d, required %0d", name, ld_total - snap_ld, e.ld);
        end
        @(negedge clk);
        checks++;
        if (cmd_done !== 1'b0 || done_total - snap_done != 1) begin
            errors++;
            $display("FAIL %s_done_pulse: cmd_done=%b pulses=%0d, required 0/1", name, cmd_done, done_total - snap_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h, required %h", out_vec, RESET_VEC);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_reset_midstream();
        int d0;
        send_cmd(OP_LOAD, 16'd100, 8'd0);
        wait_done("mid_load");
        send_cmd(OP_UP, 16'd0, 8'd20);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset_values: got %h, required %h", out_vec, RESET_VEC);
        end
        sb.delete();
        d0 = done_total;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_early: got %b, required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready_release: got %b, required 1", cmd_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_total != d0 || cnt_count_enb !== 1'b0) begin
            errors++;
            $display("FAIL mid_dropped: done pulses=%0d enb=%b, required 0/0", done_total - d0, cnt_count_enb);
        end
    endtask

    task automatic test_load_up();
        send_cmd(OP_LOAD, 16'd7, 8'd0);
        wait_done("load7");
        send_cmd(OP_UP, 16'd0, 8'd5);
        wait_done("up5");
    endtask

    task automatic test_wrap();
        send_cmd(OP_LOAD, 16'hFFFE, 8'd0);
        wait_done("load_fffe");
        send_cmd(OP_UP, 16'd0, 8'd3);
        wait_done("wrap_up3");
        send_cmd(OP_DOWN, 16'd0, 8'd2);
        wait_done("wrap_down2");
    endtask

    task automatic test_hold_zero_len();
        send_cmd(OP_LOAD, 16'd9, 8'd0);
        wait_done("load9");
        send_cmd(OP_HOLD, 16'hABCD, 8'd4);
        wait_done("hold4");
        send_cmd(OP_UP, 16'd0, 8'd0);
        wait_done("up0");
    endtask

    task automatic test_ignore_busy();
        int d0;
        send_cmd(OP_LOAD, 16'h0300, 8'd0);
        wait_done("busy_load");
        send_cmd(OP_UP, 16'd0, 8'd6);
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'(i);
            cmd_data  = 16'h1234 + 16'(i);
            cmd_len   = 8'd2;
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready: got %b in cycle %0d, required 0", cmd_ready, i);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        wait_done("busy_up6");
        d0 = done_total;
        repeat (4) @(negedge clk);
        checks++;
        if (done_total != d0 || cmd_ready !== 1'b1 || exp_value !== 16'h0306) begin
            errors++;
            $display("FAIL busy_no_extra: pulses=%0d ready=%b exp=%h, required 0/1/0306", done_total - d0, cmd_ready, exp_value);
        end
    endtask

    task automatic test_fault();
        send_cmd(OP_LOAD, 16'd54, 8'd0);
        wait_done("fault_load");
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL fault_pre_err: got %0d, required 0", err_count);
        end
        fault = 1'b1;
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL fault_first: mismatch=%b err=%0d, required 1/1", mismatch, err_count);
        end
        @(negedge clk);
        checks++;
        if (err_count !== 8'd2) begin
            errors++;
            $display("FAIL fault_second: err=%0d, required 2", err_count);
        end
        repeat (260) @(negedge clk);
        checks++;
        if (err_count !== 8'd255 || mismatch !== 1'b1) begin
            errors++;
            $display("FAIL fault_saturate: err=%0d mismatch=%b, required 255/1", err_count, mismatch);
        end
        fault = 1'b0;
        @(negedge clk);
        checks++;
        if (mismatch !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: mismatch=%b, required 1", mismatch);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mismatch !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL fault_clear: mismatch=%b err=%0d, required 0/0", mismatch, err_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 16'h0000;
        cmd_len   = 8'd0;
        chk_en    = 1'b1;
        test_reset();
        test_reset_midstream();
        test_load_up();
        test_wrap();
        test_hold_zero_len();
        test_ignore_busy();
        test_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
